// File: rtl/iic_target.sv
// I2C target: synchronized and filtered SCL/SDA, 7-bit address match,
// byte write to rx_data and byte read from tx_data, always-ACK on writes.
module iic_target #(
  parameter logic [6:0] ADDR = 7'h50,
  parameter int         FILT = 3
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  localparam logic [3:0] FLIM = 4'(FILT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA,
    S_WR_ACK, S_RD_DATA, S_RD_ACK, S_IGNORE
  } state_t;

  state_t     state;
  logic [1:0] scl_s, sda_s;
  logic [3:0] scl_c, sda_c;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic [7:0] sr;
  logic [2:0] bcnt;
  logic       rw, ack_on;

  logic       scl_rise, scl_fall, start_c, stop_c;
  logic [7:0] byte_in;
  logic       match;

  assign sda_o    = 1'b0;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;
  assign byte_in  = {sr[6:0], sda_f};
  assign match    = (byte_in[7:1] == ADDR) &&
                    (byte_in[7:1] != 7'd0);

  // a new level is accepted only after FILT consecutive differing samples
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
      scl_c <= '0;
      sda_c <= '0;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_s <= {scl_s[0], scl_i};
      sda_s <= {sda_s[0], sda_i};
      if (scl_s[1] == scl_f) begin
        scl_c <= '0;
      end else if (scl_c == FLIM) begin
        scl_f <= scl_s[1];
        scl_c <= '0;
      end else begin
        scl_c <= scl_c + 4'd1;
      end
      if (sda_s[1] == sda_f) begin
        sda_c <= '0;
      end else if (sda_c == FLIM) begin
        sda_f <= sda_s[1];
        sda_c <= '0;
      end else begin
        sda_c <= sda_c + 4'd1;
      end
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      sda_t     <= 1'b1;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      busy      <= 1'b0;
      sr        <= 8'h00;
      bcnt      <= 3'd0;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
    end else begin
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      rx_valid  <= 1'b0;
      tx_load   <= 1'b0;
      if (tx_load) sr <= tx_data;
      if (start_c) begin
        state     <= S_ADDR;
        bcnt      <= 3'd0;
        ack_on    <= 1'b0;
        sda_t     <= 1'b1;
        busy      <= 1'b1;
        start_det <= 1'b1;
      end else if (stop_c) begin
        state    <= S_IDLE;
        ack_on   <= 1'b0;
        sda_t    <= 1'b1;
        busy     <= 1'b0;
        stop_det <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: ;
          S_ADDR: if (scl_rise) begin
            sr   <= byte_in;
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              rw    <= byte_in[0];
              state <= match ? S_ADDR_ACK : S_IGNORE;
            end
          end
          S_ADDR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_t   <= 1'b0;
              ack_on  <= 1'b1;
              tx_load <= rw;
            end else begin
              ack_on <= 1'b0;
              bcnt   <= 3'd0;
              sda_t  <= rw ? sr[7] : 1'b1;
              state  <= rw ? S_RD_DATA : S_WR_DATA;
            end
          end
          S_WR_DATA: if (scl_rise) begin
            sr   <= byte_in;
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              rx_data  <= byte_in;
              rx_valid <= 1'b1;
              state    <= S_WR_ACK;
            end
          end
          S_WR_ACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_t  <= 1'b0;
              ack_on <= 1'b1;
            end else begin
              sda_t  <= 1'b1;
              ack_on <= 1'b0;
              bcnt   <= 3'd0;
              state  <= S_WR_DATA;
            end
          end
          // bit 7 is already on the bus when this state is entered
          S_RD_DATA: if (scl_fall) begin
            if (bcnt == 3'd7) begin
              sda_t <= 1'b1;
              bcnt  <= 3'd0;
              state <= S_RD_ACK;
            end else begin
              sda_t <= sr[6];
              sr    <= {sr[6:0], 1'b0};
              bcnt  <= bcnt + 3'd1;
            end
          end
          S_RD_ACK: begin
            if (scl_rise && !ack_on) begin
              if (!sda_f) begin
                tx_load <= 1'b1;
                ack_on  <= 1'b1;
              end else begin
                state <= S_IGNORE;
              end
            end else if (scl_fall && ack_on) begin
              sda_t  <= sr[7];
              ack_on <= 1'b0;
              bcnt   <= 3'd0;
              state  <= S_RD_DATA;
            end
          end
          S_IGNORE: sda_t <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_target.sv
// Directed bench for iic_target: write, read, mismatch,
// repeated START, glitch rejection and reset mid-ACK.
module tb_iic_target;

  localparam int Q = 16;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_o, sda_t;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_load, start_det, stop_det, busy;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0, n_txl = 0;
  logic low_seen = 1'b0;

  assign sda_bus = sda_m & (sda_t | sda_o);

  always #5 aclk = ~aclk;

  iic_target dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .scl_i     (scl_m),
    .sda_i     (sda_bus),
    .sda_o     (sda_o),
    .sda_t     (sda_t),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_load   (tx_load),
    .start_det (start_det),
    .stop_det  (stop_det),
    .busy      (busy)
  );

  always @(posedge aclk) begin
    if (start_det) n_start++;
    if (stop_det)  n_stop++;
    if (rx_valid)  n_rxv++;
    if (tx_load)   n_txl++;
    if (!sda_t)    low_seen = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    r = sda_bus;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic do_start();
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_x(b[i], r);
    bit_x(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d,
                           input logic m_ack,
                           input logic [7:0] nxt);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, r);
      d[i] = r;
    end
    tx_data = nxt;
    bit_x(m_ack, r);
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] b;
    int s_st, s_sp, s_rx, s_tx;
    int k;

    // reset values
    tick(3);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_pulses", {rx_valid, tx_load, start_det, stop_det}, 0);
    aresetn = 1'b1;
    tick(10);

    // write 0x5A
    s_st = n_start; s_sp = n_stop; s_rx = n_rxv;
    do_start();
    chk("wr_busy", busy, 1);
    write_byte(8'hA0, a);
    chk("wr_addr_ack", a, 0);
    write_byte(8'h5A, a);
    chk("wr_data_ack", a, 0);
    do_stop();
    tick(Q);
    chk("wr_rx_data", rx_data, 8'h5A);
    chk("wr_rxv_cnt", n_rxv - s_rx, 1);
    chk("wr_start_cnt", n_start - s_st, 1);
    chk("wr_stop_cnt", n_stop - s_sp, 1);
    chk("wr_busy_end", busy, 0);

    // read 0xC3 (ACK) then 0x3C (NACK)
    s_tx = n_txl;
    tx_data = 8'hC3;
    do_start();
    write_byte(8'hA1, a);
    chk("rd_addr_ack", a, 0);
    read_byte(d, 1'b0, 8'h3C);
    chk("rd_byte1", d, 8'hC3);
    read_byte(d, 1'b1, 8'h00);
    chk("rd_byte2", d, 8'h3C);
    chk("rd_nack_rel", sda_t, 1);
    do_stop();
    tick(Q);
    chk("rd_txl_cnt", n_txl - s_tx, 2);

    // address mismatch
    s_rx = n_rxv;
    low_seen = 1'b0;
    do_start();
    chk("mm_busy", busy, 1);
    write_byte(8'hA2, a);
    chk("mm_addr_nack", a, 1);
    write_byte(8'h11, a);
    chk("mm_data_nack", a, 1);
    do_stop();
    tick(Q);
    chk("mm_no_drive", low_seen, 0);
    chk("mm_rxv_cnt", n_rxv - s_rx, 0);
    chk("mm_busy_end", busy, 0);

    // repeated START
    s_st = n_start; s_tx = n_txl;
    tx_data = 8'h96;
    do_start();
    write_byte(8'hA0, a);
    chk("sr_wr_ack", a, 0);
    write_byte(8'h01, a);
    chk("sr_data_ack", a, 0);
    do_start();
    write_byte(8'hA1, a);
    chk("sr_rd_ack", a, 0);
    read_byte(d, 1'b1, 8'h00);
    chk("sr_rd_byte", d, 8'h96);
    do_stop();
    tick(Q);
    chk("sr_rx_data", rx_data, 8'h01);
    chk("sr_start_cnt", n_start - s_st, 2);
    chk("sr_txl_cnt", n_txl - s_tx, 1);

    // 1-cycle SDA glitch with SCL high
    s_st = n_start;
    sda_m = 1'b0;
    tick(1);
    sda_m = 1'b1;
    tick(20);
    chk("gl_no_start", n_start - s_st, 0);
    chk("gl_busy", busy, 0);

    // reset during the address ACK of a read
    tx_data = 8'hC3;
    b = 8'hA1;
    do_start();
    for (int i = 7; i >= 0; i--) bit_x(b[i], a);
    sda_m = 1'b1;
    k = 0;
    while (sda_t !== 1'b0 && k < 4 * Q) begin
      tick(1);
      k++;
    end
    chk("rs_ack_drive", sda_t, 0);
    @(posedge aclk);
    #2 aresetn = 1'b0;
    #1 chk("rs_async_rel", sda_t, 1);
    chk("rs_busy", busy, 0);
    tick(Q);
    scl_m = 1'b1;
    tick(2 * Q);
    scl_m = 1'b0;
    tick(Q);
    do_stop();
    aresetn = 1'b1;
    tick(10);
    s_st = n_start; s_rx = n_rxv;
    write_byte(8'hA0, a);
    chk("rs_ignore_nack", a, 1);
    chk("rs_idle_busy", busy, 0);
    chk("rs_no_start", n_start - s_st, 0);
    do_start();
    write_byte(8'hA0, a);
    chk("rs_new_ack", a, 0);
    write_byte(8'h77, a);
    chk("rs_new_data_ack", a, 0);
    do_stop();
    tick(Q);
    chk("rs_new_rx", rx_data, 8'h77);
    chk("rs_rxv_cnt", n_rxv - s_rx, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
